sobel_window_gen: RTL and testbench

Streaming 3x3 window generator for the Sobel datapath. It accepts a raster-order pixel stream and keeps the two previous lines in a `sync_ram_block` line store, using one write port and two read ports. Each cycle it emits a full 3x3 neighbourhood to the downstream gradient stage. It sits directly upstream of the gradient/magnitude logic and is the sole owner and driver of the line-store RAM.

---
 rtl/sobel_pkg.sv | 11 +
 rtl/sync_ram_block.sv | 36 +++
 rtl/sobel_window_gen.sv | 102 ++++++++++
 tb/tb_sobel_window_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/window types and 3x3 window indexing for the Sobel datapath
package sobel_pkg;
    localparam int PIX_W    = 8;
    localparam int WIN_DIM  = 3;
    localparam int WIN_SIZE = WIN_DIM * WIN_DIM;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [WIN_SIZE-1:0] window_t;
    function automatic logic [3:0] win_idx(input int r, input int c);
        return 4'(r * WIN_DIM + c);
    endfunction
endpackage

// File: rtl/sync_ram_block.sv
// sync_ram_block: one write port, two registered read ports; reads return pre-write data
module sync_ram_block #(
    parameter int    WIDTH_P    = 8,
    parameter int    DEPTH_P    = 1280,
    parameter string filename_p = "",
    localparam int   ADDR_W     = $clog2(DEPTH_P)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [WIDTH_P-1:0] wdata_i,
    input  logic               re_a_i,
    input  logic [ADDR_W-1:0]  addr_a_i,
    output logic [WIDTH_P-1:0] data_a_o,
    input  logic               re_b_i,
    input  logic [ADDR_W-1:0]  addr_b_i,
    output logic [WIDTH_P-1:0] data_b_o
);
    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [WIDTH_P-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    // Contents are never preloaded in hardware; a named file is ignored.
    if (filename_p != "") begin : g_no_preload
    end
    always_comb begin
        data_a_d = !rstn_i ? '0 : re_a_i ? mem_q[addr_a_i] : data_a_q;
        data_b_d = !rstn_i ? '0 : re_b_i ? mem_q[addr_b_i] : data_b_q;
    end
    always_ff @(posedge clk_i) begin
        data_a_q <= data_a_d;
        data_b_q <= data_b_d;
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator with a two-bank line store
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [WIDTH_P-1:0]          pixel_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [WIN_SIZE*WIDTH_P-1:0] window_o,
    output logic                        valid_o,
    input  logic                        ready_i
);
    localparam int COL_W  = $clog2(LINE_W_P);
    localparam int ROW_W  = $clog2(FRAME_H_P);
    localparam int ADDR_W = $clog2(2 * LINE_W_P);

    logic en, accept, last_col, last_row, shift;
    logic [COL_W-1:0] col_q, col_d, p1_col_q, p1_col_d;
    logic [ROW_W-1:0] row_q, row_d, p1_row_q, p1_row_d;
    logic p1_valid_q, p1_valid_d, valid_q, valid_d;
    logic [WIDTH_P-1:0] p1_pix_q, p1_pix_d, data_a, data_b;
    logic [WIN_SIZE-1:0][WIDTH_P-1:0] win_q, win_d;
    logic [ADDR_W-1:0] col_ext, line_off, addr_cur, addr_prev;

    always_comb begin
        en         = ready_i | ~valid_q;
        accept     = valid_i & en;
        last_col   = col_q == COL_W'(LINE_W_P - 1);
        last_row   = row_q == ROW_W'(FRAME_H_P - 1);
        col_d      = !accept ? col_q : last_col ? '0 : col_q + 1'b1;
        row_d      = !(accept && last_col) ? row_q : last_row ? '0 : row_q + 1'b1;
        col_ext    = ADDR_W'(col_q);
        line_off   = ADDR_W'(LINE_W_P);
        // Bank row[0] holds the line being written, which still contains row-2 until overwritten.
        addr_cur   = row_q[0] ? line_off + col_ext : col_ext;
        addr_prev  = row_q[0] ? col_ext : line_off + col_ext;
        p1_valid_d = en ? accept : p1_valid_q;
        p1_pix_d   = en ? pixel_i : p1_pix_q;
        p1_col_d   = en ? col_q : p1_col_q;
        p1_row_d   = en ? row_q : p1_row_q;
        shift      = en & p1_valid_q;
        win_d      = win_q;
        if (shift) begin
            for (int r = 0; r < WIN_DIM; r++)
                for (int c = 0; c < WIN_DIM - 1; c++)
                    win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
            win_d[win_idx(0, 2)] = data_b;
            win_d[win_idx(1, 2)] = data_a;
            win_d[win_idx(2, 2)] = p1_pix_q;
        end
        valid_d = en ? p1_valid_q & (p1_col_q >= COL_W'(2)) & (p1_row_q >= ROW_W'(2)) : valid_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q      <= '0;
            row_q      <= '0;
            p1_valid_q <= 1'b0;
            p1_pix_q   <= '0;
            p1_col_q   <= '0;
            p1_row_q   <= '0;
            win_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            p1_valid_q <= p1_valid_d;
            p1_pix_q   <= p1_pix_d;
            p1_col_q   <= p1_col_d;
            p1_row_q   <= p1_row_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
        end
    end

    sync_ram_block #(
        .WIDTH_P   (WIDTH_P),
        .DEPTH_P   (2 * LINE_W_P),
        .filename_p("")
    ) u_line_store (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .we_i    (accept),
        .waddr_i (addr_cur),
        .wdata_i (pixel_i),
        .re_a_i  (accept),
        .addr_a_i(addr_prev),
        .data_a_o(data_a),
        .re_b_i  (accept),
        .addr_b_i(addr_cur),
        .data_b_o(data_b)
    );

    assign ready_o  = en;
    assign valid_o  = valid_q;
    assign window_o = win_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed + randomized checks against a frame-image reference model
module tb_sobel_window_gen;
    localparam int W = 8, LW = 4, FH = 4;
    localparam logic [71:0] FIRST = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [71:0] LAST  = 72'h33_32_31_23_22_21_13_12_11;

    typedef struct {
        logic [71:0] win;
        int          cyc;
    } exp_t;

    logic clk = 1'b0, rstn_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0, ready_o, valid_o;
    logic [W-1:0] pixel_i = '0;
    logic [9*W-1:0] window_o;

    int checks = 0, failures = 0, cyc = 0, tb_r = 0, tb_c = 0;
    bit lat_mode = 0, stall_mode = 0;
    logic [7:0] img [FH][LW];
    logic [71:0] mask;
    exp_t q[$];
    logic [71:0] win_log[$];

    sobel_window_gen #(.WIDTH_P(W), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .pixel_i(pixel_i), .valid_i(valid_i), .ready_o(ready_o),
        .window_o(window_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a window exists for every accepted pixel at row>=2, col>=2 of its frame.
    task automatic model_accept(input logic [7:0] pix);
        logic [71:0] w;
        img[tb_r][tb_c] = pix;
        if (tb_r >= 2 && tb_c >= 2) begin
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    w[(rr*3+cc)*8 +: 8] = img[tb_r-2+rr][tb_c-2+cc];
            q.push_back('{w, cyc});
        end
        if (tb_c == LW - 1) begin
            tb_c = 0;
            tb_r = (tb_r == FH - 1) ? 0 : tb_r + 1;
        end else tb_c++;
    endtask

    task automatic cycle(input bit v, input logic [7:0] pix, input bit rdy, output bit acc);
        valid_i = v;
        pixel_i = pix;
        ready_i = rdy;
        @(negedge clk);
        if (rdy) check("ready_o_open", ready_o, 1);
        if (stall_mode) begin
            check("stall_valid", valid_o, 1);
            check("stall_ready", ready_o, 0);
        end
        if (lat_mode) check("valid_timing", valid_o, q.size() > 0 && q[0].cyc + 2 == cyc);
        if (valid_o === 1'b1) begin
            check("window_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                check("window_value", window_o, q[0].win);
                if (lat_mode) check("latency", cyc - q[0].cyc, 2);
                if (rdy) begin
                    win_log.push_back(window_o);
                    void'(q.pop_front());
                end
            end
        end
        acc = v && (ready_o === 1'b1);
        if (acc) model_accept(pix);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit rnd, input logic [7:0] base, input int bub,
                        input int rdy_pct, input bit bp);
        bit acc, bp_done;
        logic [7:0] pix;
        int guard;
        bp_done = 0;
        for (int i = 0; i < n; i++) begin
            pix = rnd ? 8'($urandom) : base + 8'(tb_r * 16 + tb_c);
            acc = 0;
            guard = 0;
            while (!acc && guard < 100) begin
                if (bp && !bp_done && valid_o === 1'b1) begin
                    stall_mode = 1;
                    for (int k = 0; k < 5 && !acc; k++) cycle(1, pix, 0, acc);
                    stall_mode = 0;
                    bp_done = 1;
                end else
                    cycle($urandom_range(99) >= bub, pix, $urandom_range(99) < rdy_pct, acc);
                guard++;
            end
            check("accept_timeout", acc, 1);
        end
        if (bp) check("stall_applied", bp_done, 1);
    endtask

    task automatic drain();
        bit acc;
        int g = 0;
        while (q.size() > 0 && g < 40) begin
            cycle(0, 8'h00, 1, acc);
            g++;
        end
        for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1, acc);
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_window", window_o, 0);
        check("rst_ready", ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        tb_r = 0;
        tb_c = 0;
    endtask

    initial begin
        mask = {9{8'h80}};
        do_reset();

        lat_mode = 1;
        win_log.delete();
        send(16, 0, 8'h00, 0, 100, 0);
        drain();
        check("cont_count", win_log.size(), 4);
        check("cont_first", win_log[0], FIRST);
        check("cont_last", win_log[3], LAST);

        lat_mode = 0;
        win_log.delete();
        send(16, 0, 8'h00, 0, 100, 1);
        drain();
        check("bp_count", win_log.size(), 4);
        check("bp_first", win_log[0], FIRST);
        check("bp_last", win_log[3], LAST);

        lat_mode = 1;
        win_log.delete();
        send(16, 0, 8'h00, 30, 100, 0);
        drain();
        check("bubble_count", win_log.size(), 4);
        check("bubble_first", win_log[0], FIRST);
        check("bubble_last", win_log[3], LAST);

        win_log.delete();
        send(16, 0, 8'h00, 0, 100, 0);
        send(16, 0, 8'h80, 0, 100, 0);
        drain();
        check("b2b_count", win_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check("b2b_frame_sep", win_log[i] & mask, (i < 4) ? 72'h0 : mask);
        check("b2b_f2_first", win_log[4], FIRST | mask);
        check("b2b_f2_last", win_log[7], LAST | mask);

        lat_mode = 0;
        win_log.delete();
        send(32, 1, 8'h00, 30, 70, 0);
        drain();
        check("rand_count", win_log.size(), 8);

        lat_mode = 1;
        send(10, 0, 8'h00, 0, 100, 0);
        do_reset();
        win_log.delete();
        send(16, 0, 8'h00, 0, 100, 0);
        drain();
        check("restart_count", win_log.size(), 4);
        check("restart_first", win_log[0], FIRST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
